// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one signed saturating adder among N requesters,
// with a single registered result stage and a sticky count of saturated results.
module sat_add_arbiter #(
    parameter int W   = 4,
    parameter int N   = 4,
    parameter int IDW = $clog2(N),
    parameter int CW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [IDW-1:0]   out_id,
    output logic             out_sat,
    output logic [CW-1:0]    sat_count
);

    localparam logic [W-1:0] SUM_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SUM_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]   w_a [N];
    logic [W-1:0]   w_b [N];

    logic           r_valid;
    logic [W-1:0]   r_sum;
    logic [IDW-1:0] r_id;
    logic           r_sat;
    logic [CW-1:0]  r_cnt;
    logic [IDW-1:0] r_ptr;

    logic           w_accept;
    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_fire;
    logic [IDW-1:0] w_ptr_next;
    int             w_scan_idx;

    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [W:0]     w_sum_ext;
    logic           w_ovf;
    logic [W-1:0]   w_sum_sat;
    logic           w_drain;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_a[gi] = req_a[gi*W +: W];
            assign w_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    assign w_accept = !r_valid || out_ready;

    // First valid requester at or after the pointer, wrapping modulo N.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_scan_idx = (int'(r_ptr) + k) % N;
            if (!w_gnt_any && req_valid[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDW'(w_scan_idx);
            end
        end
    end

    assign w_fire     = w_accept && w_gnt_any;
    assign req_ready  = w_fire ? (N'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == IDW'(N-1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_sel_a   = w_a[w_gnt_idx];
    assign w_sel_b   = w_b[w_gnt_idx];
    assign w_sum_ext = {w_sel_a[W-1], w_sel_a} + {w_sel_b[W-1], w_sel_b};
    // The two top bits of the extended sum disagree exactly when the W-bit result overflowed.
    assign w_ovf     = w_sum_ext[W] != w_sum_ext[W-1];
    assign w_sum_sat = !w_ovf ? w_sum_ext[W-1:0] : (w_sum_ext[W] ? SUM_MIN : SUM_MAX);

    assign w_drain = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
            r_sat   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum_sat;
            r_id    <= w_gnt_idx;
            r_sat   <= w_ovf;
            r_ptr   <= w_ptr_next;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_drain && r_sat && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign out_id    = r_id;
    assign out_sat   = r_sat;
    assign sat_count = r_cnt;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Checks sat_add_arbiter (W=4, N=4) against an arithmetic reference model, with
// a second instance at CW=2 to exercise the saturation-counter ceiling.
module tb_sat_add_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        out_ready;

    logic [3:0]  req_ready,  c_req_ready;
    logic        out_valid,  c_out_valid;
    logic [3:0]  out_sum,    c_out_sum;
    logic [1:0]  out_id,     c_out_id;
    logic        out_sat,    c_out_sat;
    logic [7:0]  sat_count;
    logic [1:0]  c_sat_count;

    int n_vec = 0;
    int n_err = 0;

    sat_add_arbiter #(.W(4), .N(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_sat(out_sat), .sat_count(sat_count)
    );

    sat_add_arbiter #(.W(4), .N(4), .CW(2)) dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c_req_ready),
        .req_a(req_a), .req_b(req_b), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_sum(c_out_sum), .out_id(c_out_id), .out_sat(c_out_sat), .sat_count(c_sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_valid;
    logic [3:0] m_sum;
    logic [1:0] m_id;
    logic       m_sat;
    int         m_ptr;
    int         m_cnt;

    function automatic int model_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Returns {sat, sum}: plain integer addition then clamp to the 4-bit signed range.
    function automatic logic [4:0] model_add(input logic [15:0] a, input logic [15:0] b, input int i);
        logic [3:0] av;
        logic [3:0] bv;
        int s;
        if (i < 0) return 5'd0;
        av = a[i*4 +: 4];
        bv = b[i*4 +: 4];
        s = int'($signed(av)) + int'($signed(bv));
        if (s > 7)  return {1'b1, 4'h7};
        if (s < -8) return {1'b1, 4'h8};
        return {1'b0, 4'(s)};
    endfunction

    int         e_grant;
    logic [4:0] e_add;
    logic [3:0] e_ready;

    always_comb begin
        e_grant = (!m_valid || out_ready) ? model_grant(req_valid, m_ptr) : -1;
        e_add   = model_add(req_a, req_b, e_grant);
        e_ready = (e_grant >= 0) ? 4'(1 << e_grant) : 4'd0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_id    <= '0;
            m_sat   <= 1'b0;
            m_ptr   <= 0;
            m_cnt   <= 0;
        end else begin
            if (m_valid && out_ready && m_sat) m_cnt <= m_cnt + 1;
            if (e_grant >= 0) begin
                m_valid <= 1'b1;
                m_id    <= 2'(e_grant);
                m_sum   <= e_add[3:0];
                m_sat   <= e_add[4];
                m_ptr   <= (e_grant + 1) % 4;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", req_ready, e_ready);
        chk("c_req_ready", c_req_ready, e_ready);
        chk("out_valid", out_valid, m_valid);
        chk("c_out_valid", c_out_valid, m_valid);
        if (m_valid) begin
            chk("out_sum", out_sum, m_sum);
            chk("out_id", out_id, m_id);
            chk("out_sat", out_sat, m_sat);
            chk("c_out_sum", c_out_sum, m_sum);
        end
        chk("sat_count", sat_count, (m_cnt > 255) ? 255 : m_cnt);
        chk("c_sat_count", c_sat_count, (m_cnt > 3) ? 3 : m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    initial begin
        logic [1:0] rr_ids [9];
        rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};

        rst = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_sat_count", sat_count, 0);
        repeat (2) tick();
        rst = 1'b1;

        // single grant
        tick();
        req_valid = 4'b0001;
        set_op(0, 4'b0011, 4'b0010);
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_sum", out_sum, 4'b0101);
        chk("t1_out_id", out_id, 0);
        chk("t1_out_sat", out_sat, 0);
        tick();

        // saturation on requester 2
        req_valid = 4'b0100;
        set_op(2, 4'b0111, 4'b0001);
        tick();
        chk("sat_pos_sum", out_sum, 4'b0111);
        chk("sat_pos_flag", out_sat, 1);
        set_op(2, 4'b1000, 4'b1111);
        tick();
        chk("sat_neg_sum", out_sum, 4'b1000);
        chk("sat_neg_flag", out_sat, 1);
        set_op(2, 4'b1100, 4'b0111);
        tick();
        req_valid = '0;
        chk("nosat_sum", out_sum, 4'b0011);
        chk("nosat_flag", out_sat, 0);
        chk("sat_count_2", sat_count, 2);
        tick();

        // bring pointer to 0, then round-robin with all requesters valid
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_id", out_id, rr_ids[i]);
        end
        req_valid = 4'b1010;
        for (int i = 6; i < 9; i++) begin
            tick();
            chk("rr_sparse_id", out_id, rr_ids[i]);
        end

        // backpressure
        req_valid = 4'b0010;
        set_op(1, 4'd2, 4'd3);
        tick();
        chk("bp_id", out_id, 1);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("bp_req_ready", req_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sum", out_sum, 4'd5);
            chk("bp_hold_id", out_id, 1);
            chk("bp_hold_ready", req_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0100);
        tick();
        chk("bp_release_id", out_id, 2);

        // build sat_count to 5 with a result stalled, then reset between edges
        req_valid = 4'b0001;
        set_op(0, 4'd7, 4'd7);
        repeat (4) tick();
        out_ready = 1'b0;
        req_valid = '0;
        chk("pre_rst_count", sat_count, 5);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", sat_count, 0);
        chk("mid_rst_c_count", c_sat_count, 0);
        chk("mid_rst_sum", out_sum, 0);
        repeat (2) tick();
        rst = 1'b1;

        // first grant after reset goes to 0; every result saturates
        for (int i = 0; i < 4; i++) set_op(i, 4'h8, 4'h8);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 4'b0001);
        tick();
        chk("post_rst_id", out_id, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("ceil_c_count", c_sat_count, (i > 3) ? 3 : i);
            chk("ceil_count", sat_count, i);
        end
        req_valid = '0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
